// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel word type and colour expansion helpers.
package vga_pkg;

  // 640x480 @ 60 Hz industry timing, pixel clock 25 MHz nominal
  localparam int H_VIS_DEF   = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_VIS_DEF   = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;
  localparam int H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Drawer output word: 3 bits red, 3 bits green, 2 bits blue
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Bit replication so that 0 maps to 00 and full scale maps to FF
  function automatic logic [7:0] expand3to8(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] expand2to8(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised shift register that delays a small bundle of timing bits
// so they line up with pixel data coming back from the drawer pipeline.
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift raw bits through DEPTH stages; reset loads the idle pattern everywhere
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan generator: produces pixel coordinates for the drawers, delays
// sync/blank to match drawer latency, and expands RGB332 to 8:8:8 on the pins.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_VIS      = H_VIS_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_VIS      = V_VIS_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] C_H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_H_VIS  = 11'(H_VIS);
  localparam logic [10:0] C_V_VIS  = 11'(V_VIS);
  localparam logic [10:0] C_HS_BEG = 11'(H_VIS + H_FP);
  localparam logic [10:0] C_HS_END = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] C_VS_BEG = 11'(V_VIS + V_FP);
  localparam logic [10:0] C_VS_END = 11'(V_VIS + V_FP + V_SYNC);

  // Idle pattern for {hsync, vsync, active}: syncs deasserted, not visible
  localparam logic [2:0] C_IDLE = 3'b110;

  logic [10:0] r_pixel_x;
  logic [10:0] r_pixel_y;
  logic        r_sof;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank_n;
  logic [7:0]  r_red;
  logic [7:0]  r_green;
  logic [7:0]  r_blue;

  logic        w_active_raw;
  logic        w_hsync_raw;
  logic        w_vsync_raw;
  logic [2:0]  w_dly;
  logic        w_frame_last;
  rgb332_t     w_rgb;

  // Raster counters: X wraps each line, Y advances on the X wrap
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pixel_x <= '0;
      r_pixel_y <= '0;
    end else if (r_pixel_x == C_H_LAST) begin
      r_pixel_x <= '0;
      if (r_pixel_y == C_V_LAST) begin
        r_pixel_y <= '0;
      end else begin
        r_pixel_y <= r_pixel_y + 11'd1;
      end
    end else begin
      r_pixel_x <= r_pixel_x + 11'd1;
    end
  end

  assign w_active_raw = (r_pixel_x < C_H_VIS) && (r_pixel_y < C_V_VIS);
  assign w_hsync_raw  = !((r_pixel_x >= C_HS_BEG) && (r_pixel_x < C_HS_END));
  assign w_vsync_raw  = !((r_pixel_y >= C_VS_BEG) && (r_pixel_y < C_VS_END));
  assign w_frame_last = (r_pixel_x == C_H_LAST) && (r_pixel_y == C_V_LAST);
  assign w_rgb        = RGBIn;

  // One delay line carries all three timing bits so they can never skew
  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (C_IDLE)
  ) u_sync_delay (
    .i_clk   (clk),
    .i_rst_n (resetN),
    .i_data  ({w_hsync_raw, w_vsync_raw, w_active_raw}),
    .o_data  (w_dly)
  );

  // Start-of-frame strobe lands while the counters read (0,0)
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sof <= 1'b0;
    end else begin
      r_sof <= w_frame_last;
    end
  end

  // Pin register: colour is forced to zero outside the visible area
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
    end else begin
      r_hsync   <= w_dly[2];
      r_vsync   <= w_dly[1];
      r_blank_n <= w_dly[0];
      if (w_dly[0]) begin
        r_red   <= expand3to8(w_rgb.r);
        r_green <= expand3to8(w_rgb.g);
        r_blue  <= expand2to8(w_rgb.b);
      end else begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end
    end
  end

  assign pixelX       = r_pixel_x;
  assign pixelY       = r_pixel_y;
  assign startOfFrame = r_sof;
  assign hSync        = r_hsync;
  assign vSync        = r_vsync;
  assign blankN       = r_blank_n;
  assign red          = r_red;
  assign green        = r_green;
  assign blue         = r_blue;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl using a reduced raster so whole frames fit in
// a short run. A drawer model feeds RGBIn with the pipeline latency and a
// scoreboard queue holds the expected pin word for every clock.
module tb_vga_timing_ctrl;

  localparam int HV = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VV = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int PD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int W  = 27;

  // {hSync, vSync, blankN, red, green, blue} while in reset
  localparam logic [W-1:0] RESET_PINS = {1'b1, 1'b1, 1'b0, 24'h000000};

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [7:0]  RGBIn = 8'h00;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        hSync;
  logic        vSync;
  logic        blankN;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .RGBIn        (RGBIn),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .startOfFrame (startOfFrame),
    .hSync        (hSync),
    .vSync        (vSync),
    .blankN       (blankN),
    .red          (red),
    .green        (green),
    .blue         (blue)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   drv_q[$];

  int   mx;
  int   my;
  logic sof_exp;
  int   mode;
  int   sof_cnt;
  int   marker_cnt;
  logic hs_prev, vs_prev, bl_prev;
  bit   hs_valid, vs_valid, bl_valid;
  int   hs_len, vs_len, bl_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] x3(input logic [2:0] c);
    return {c, c, c[2:1]};
  endfunction

  function automatic logic [7:0] x2(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  function automatic bit is_act(input int x, input int y);
    return (x < HV) && (y < VV);
  endfunction

  // Drawer behaviour: 0 constant colour, 1 marker at x=0, 2 random
  function automatic logic [7:0] drawer(input int x, input int y);
    if (mode == 0) return 8'b111_101_01;
    if (!is_act(x, y)) return 8'hxx;
    if (mode == 1) return (x == 0) ? 8'hE0 : 8'h00;
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [W-1:0] pins_for(input int x, input int y, input logic [7:0] d);
    logic hs;
    logic vs;
    hs = !((x >= HV + HF) && (x < HV + HF + HS));
    vs = !((y >= VV + VF) && (y < VV + VF + VS));
    if (is_act(x, y)) return {hs, vs, 1'b1, x3(d[7:5]), x3(d[4:2]), x2(d[1:0])};
    return {hs, vs, 1'b0, 24'h000000};
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},    32'(pixelX), 32'd0);
    check({tag, "_y"},    32'(pixelY), 32'd0);
    check({tag, "_sof"},  32'(startOfFrame), 32'd0);
    check({tag, "_pins"}, 32'({hSync, vSync, blankN, red, green, blue}), 32'(RESET_PINS));
  endtask

  // Per-cycle bookkeeping: compare, push new expectation, pop the due one
  task automatic bookkeep();
    logic [7:0]   d;
    logic [W-1:0] e;
    check("pixelX", 32'(pixelX), 32'(mx));
    check("pixelY", 32'(pixelY), 32'(my));
    check("startOfFrame", 32'(startOfFrame), 32'(sof_exp));
    if (startOfFrame === 1'b1) sof_cnt++;
    d = drawer(mx, my);
    drv_q.push_back(d);
    exp_q.push_back(pins_for(mx, my, d));
    e = exp_q.pop_front();
    check("pins", 32'({hSync, vSync, blankN, red, green, blue}), 32'(e));
    if (blankN === 1'b1 && red === 8'hFF) marker_cnt++;
    RGBIn = drv_q.pop_front();
    // hSync pulse position and width
    if (hs_prev === 1'b1 && hSync === 1'b0) begin
      check("hsync_start_x", 32'(mx), 32'(HV + HF + PD + 1));
      hs_valid = 1'b1;
      hs_len = 0;
    end
    if (hSync === 1'b0) hs_len++;
    if (hs_prev === 1'b0 && hSync === 1'b1 && hs_valid) check("hsync_width", 32'(hs_len), 32'(HS));
    hs_prev = hSync;
    // vSync pulse position and width
    if (vs_prev === 1'b1 && vSync === 1'b0) begin
      check("vsync_start_x", 32'(mx), 32'(PD + 1));
      check("vsync_start_y", 32'(my), 32'(VV + VF));
      vs_valid = 1'b1;
      vs_len = 0;
    end
    if (vSync === 1'b0) vs_len++;
    if (vs_prev === 1'b0 && vSync === 1'b1 && vs_valid) check("vsync_width", 32'(vs_len), 32'(VS * HT));
    vs_prev = vSync;
    // blankN visible window per line
    if (bl_prev === 1'b0 && blankN === 1'b1) begin
      check("blank_start_x", 32'(mx), 32'(PD + 1));
      bl_valid = 1'b1;
      bl_len = 0;
    end
    if (blankN === 1'b1) bl_len++;
    if (bl_prev === 1'b1 && blankN === 1'b0 && bl_valid) check("blank_width", 32'(bl_len), 32'(HV));
    bl_prev = blankN;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sof_exp = (mx == HT - 1) && (my == VT - 1);
    if (mx == HT - 1) begin
      mx = 0;
      my = (my == VT - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    bookkeep();
  endtask

  task automatic do_reset(input string tag);
    resetN = 1'b0;
    #1;
    check_reset_vals({tag, "_async"});
    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset_vals({tag, "_hold"});
    end
    resetN = 1'b1;
    mx = 0;
    my = 0;
    sof_exp = 1'b0;
    exp_q.delete();
    drv_q.delete();
    repeat (3) exp_q.push_back(RESET_PINS);
    repeat (2) drv_q.push_back(8'hxx);
    hs_prev = 1'b1;
    vs_prev = 1'b1;
    bl_prev = 1'b0;
    hs_valid = 1'b0;
    vs_valid = 1'b0;
    bl_valid = 1'b0;
    bookkeep();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    mode = 0;
    sof_cnt = 0;
    marker_cnt = 0;
    #2;
    do_reset("rst_init");

    // One full frame: exactly one strobe, at the second (0,0)
    sof_cnt = 0;
    repeat (HT * VT) step();
    check("sof_count_first_frame", 32'(sof_cnt), 32'd1);

    // Constant colour on visible pixels, zero when blanked
    for (int i = 0; i < 2 * HT && blankN !== 1'b1; i++) step();
    check("const_blank_seen_high", 32'(blankN), 32'd1);
    check("const_red",   32'(red),   32'hFF);
    check("const_green", 32'(green), 32'hB6);
    check("const_blue",  32'(blue),  32'h55);
    for (int i = 0; i < 2 * HT && blankN !== 1'b0; i++) step();
    check("const_blank_seen_low", 32'(blankN), 32'd0);
    check("blank_rgb", 32'({red, green, blue}), 32'h000000);
    repeat (HT * VT) step();

    // Marker at x=0 only, X on RGBIn during blanking
    mode = 1;
    for (int i = 0; i < 2 * HT * VT && !(mx == 0 && my == VV); i++) step();
    check("marker_window_reached", 32'(mx == 0 && my == VV), 32'd1);
    marker_cnt = 0;
    repeat (HT * VT) step();
    check("marker_count", 32'(marker_cnt), 32'(VV));

    // Random colours
    mode = 2;
    repeat (HT * VT) step();

    // Mid-frame reset
    mode = 0;
    for (int i = 0; i < 2 * HT * VT && !(mx == 10 && my == 5); i++) step();
    check("midreset_point_reached", 32'(mx == 10 && my == 5), 32'd1);
    do_reset("rst_mid");
    step();
    check("post_rst_x", 32'(pixelX), 32'd1);
    check("post_rst_y", 32'(pixelY), 32'd0);
    check("post_rst_hsync", 32'(hSync), 32'd1);
    repeat (HT * VT + HT) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
